// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider / tick generator.
// Each channel emits a one-cycle tick and a 50% square wave. The divisor is the
// half-period in clk cycles. A new divisor is staged in a shadow register and
// only becomes active at the channel's next wrap, so a running half-period is
// never cut short or stretched.
// Optional feature macro: CLK_DIV_SYNC_EN adds the `sync` input, which zeroes
// every channel at once and applies the staged divisors immediately.
module clk_div_multi #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 32'd500_000,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CH_W:0]    NUM_CH_C  = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_r        [NUM_CH];
    logic [CNT_W-1:0]  active_div_r [NUM_CH];
    logic [CNT_W-1:0]  shadow_div_r [NUM_CH];
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] clk_out_r;
    logic [NUM_CH-1:0] wrap_s;
    logic [NUM_CH-1:0] wr_sel_s;
    logic              cfg_ok_s;

    // Qualify config writes (non-zero divisor, existing channel) and find wrapping channels.
    always_comb begin
        cfg_ok_s = cfg_we && (cfg_div != ZERO_C) && ({1'b0, cfg_ch} < NUM_CH_C);
        wrap_s   = {NUM_CH{1'b0}};
        wr_sel_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            // cnt never exceeds active_div-1, so this equality is the only wrap condition.
            wrap_s[i] = (cnt_r[i] == (active_div_r[i] - ONE_C));
            if (cfg_ok_s && (cfg_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Shadow divisor staging; the last write before a wrap is the one that gets applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_div_r[i] <= DEF_DIV_C;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel_s[i]) begin
                    shadow_div_r[i] <= cfg_div;
                end else begin
                    shadow_div_r[i] <= shadow_div_r[i];
                end
            end
        end
    end

    // Per-channel counter, tick strobe, square output and wrap-time divisor load.
    // The wrap reads the shadow value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]        <= ZERO_C;
                active_div_r[i] <= DEF_DIV_C;
            end
            tick_r    <= {NUM_CH{1'b0}};
            clk_out_r <= {NUM_CH{1'b0}};
        end
`ifdef CLK_DIV_SYNC_EN
        else if (sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]        <= ZERO_C;
                active_div_r[i] <= shadow_div_r[i];
            end
            tick_r    <= {NUM_CH{1'b0}};
            clk_out_r <= {NUM_CH{1'b0}};
        end
`endif
        else if (en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap_s[i]) begin
                    cnt_r[i]        <= ZERO_C;
                    tick_r[i]       <= 1'b1;
                    clk_out_r[i]    <= ~clk_out_r[i];
                    active_div_r[i] <= shadow_div_r[i];
                end else begin
                    cnt_r[i]        <= cnt_r[i] + ONE_C;
                    tick_r[i]       <= 1'b0;
                end
            end
        end else begin
            tick_r <= {NUM_CH{1'b0}};
        end
    end

    assign tick    = tick_r;
    assign clk_out = clk_out_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: 3 channels, 16-bit counters, reset divisor 5.
// The driver pushes the expected {tick, clk_out} for every edge it issues;
// the monitor pops and compares after each posedge. Directed spot checks
// with hand-derived constants are made at key points of each scenario.
module tb_clk_div_multi;

    localparam int NUM = 3;
    localparam int CW  = 2;
    localparam int DEF = 5;
`ifdef CLK_DIV_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            en;
    logic            cfg_we;
    logic [CW-1:0]   cfg_ch;
    logic [15:0]     cfg_div;
    logic            sync;
    logic [NUM-1:0]  tick;
    logic [NUM-1:0]  clk_out;

    clk_div_multi #(
        .NUM_CH  (NUM),
        .CNT_W   (16),
        .DEF_DIV (DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef CLK_DIV_SYNC_EN
        .sync    (sync),
`endif
        .tick    (tick),
        .clk_out (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int t0_cnt = 0;
    logic [5:0] exp_q[$];

    // Reference state: edges remaining until the next tick, staged divisor, outputs.
    int rem  [NUM];
    int shad [NUM];
    bit tk   [NUM];
    bit co   [NUM];

    task automatic model_edge(input logic r, input logic e, input logic we,
                              input int ch, input int dv, input logic s);
        int old_shad [NUM];
        for (int i = 0; i < NUM; i++) old_shad[i] = shad[i];
        for (int i = 0; i < NUM; i++) begin
            if (r) begin
                rem[i] = DEF; shad[i] = DEF; tk[i] = 1'b0; co[i] = 1'b0;
            end else if (s && SYNC_ON) begin
                rem[i] = old_shad[i]; tk[i] = 1'b0; co[i] = 1'b0;
            end else if (e) begin
                if (rem[i] == 1) begin
                    tk[i] = 1'b1; co[i] = ~co[i]; rem[i] = old_shad[i];
                end else begin
                    tk[i] = 1'b0; rem[i] = rem[i] - 1;
                end
            end else begin
                tk[i] = 1'b0;
            end
        end
        if (!r && we && dv != 0 && ch < NUM) shad[ch] = dv;
    endtask

    function automatic logic [5:0] pack_exp();
        logic [5:0] v;
        for (int i = 0; i < NUM; i++) begin
            v[NUM + i] = tk[i];
            v[i]       = co[i];
        end
        return v;
    endfunction

    // One clock edge: drive inputs on negedge, record expectation, return just after posedge.
    task automatic step(input logic r, input logic e, input logic we,
                        input logic [CW-1:0] ch, input logic [15:0] dv, input logic s);
        @(negedge clk);
        rst = r; en = e; cfg_we = we; cfg_ch = ch; cfg_div = dv; sync = s;
        model_edge(r, e, we, int'(ch), int'(dv), s);
        exp_q.push_back(pack_exp());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
    endtask

    task automatic hand_check(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %b, expected %b at %0t", nm, act, req, $time);
    endtask

    // Monitor: compare every issued edge against the scoreboard.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (tick[0] === 1'b1) t0_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({tick, clk_out} === e) passes++;
                else $display("FAIL edge_out: got tick/clk_out=%b, expected %b at %0t",
                              {tick, clk_out}, e, $time);
            end
        end
    end

    initial begin
        int guard;
        logic prev_co;
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0; sync = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            rem[i] = DEF; shad[i] = DEF; tk[i] = 1'b0; co[i] = 1'b0;
        end

        // 1: reset defaults, first tick on edge 5, period 5, clk_out period 10.
        step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
        hand_check("reset_outputs", {2'b00, tick, clk_out}, 8'h00);
        t0_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            run(1);
            if (k == 4)  hand_check("no_tick_edge4", {7'd0, tick[0]}, 8'd0);
            if (k == 5)  hand_check("first_tick_edge5", {6'd0, tick[0], clk_out[0]}, 8'd3);
            if (k == 10) hand_check("clk_out_low_edge10", {6'd0, tick[0], clk_out[0]}, 8'd2);
        end
        #1;
        hand_check("tick0_count_15", 8'(t0_cnt), 8'd3);

        // 2: reprogram ch1 to 3 mid-count; the current interval of 5 completes first.
        run(2);
        step(1'b0, 1'b1, 1'b1, 2'd1, 16'd3, 1'b0);
        run(15);

        // 3: write ch0 div=2 on its wrap edge -> next interval 5, then 2; illegal writes ignored.
        guard = 0;
        while (rem[0] != 1 && guard < 20) begin
            run(1);
            guard++;
        end
        step(1'b0, 1'b1, 1'b1, 2'd0, 16'd2, 1'b0);
        run(12);
        step(1'b0, 1'b1, 1'b1, 2'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd3, 16'd7, 1'b0);
        run(10);

        // 4: enable gating with D=5: hold 7 cycles at cnt=2, then resume.
        step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        run(2);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        hand_check("held_outputs", {2'b00, tick, clk_out}, 8'h00);
        run(8);

        // 5: mid-run reset at cnt=3, restart; then ch2 div=1 gives a constant tick.
        step(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
        run(3);
        step(1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
        hand_check("midrun_reset", {2'b00, tick, clk_out}, 8'h00);
        run(5);
        hand_check("restart_tick_edge5", {2'b00, tick, clk_out}, 8'h3F);
        step(1'b0, 1'b1, 1'b1, 2'd2, 16'd1, 1'b0);
        run(12);
        prev_co = clk_out[2];
        run(1);
        hand_check("div1_tick_toggle", {6'd0, tick[2], clk_out[2]}, {6'd0, 1'b1, ~prev_co});

`ifdef CLK_DIV_SYNC_EN
        // 6: ch0=4, ch1=6 free-running, sync zeroes all; both tick on the 12th edge after.
        step(1'b0, 1'b1, 1'b1, 2'd0, 16'd4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd1, 16'd6, 1'b0);
        run(25);
        step(1'b0, 1'b1, 1'b1, 2'd2, 16'd3, 1'b1);
        hand_check("sync_zero", {2'b00, tick, clk_out}, 8'h00);
        run(12);
        hand_check("sync_aligned_tick", {6'd0, tick[1:0]}, 8'd3);
        run(6);
`endif

        #30;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
